mp_fifo: RTL and testbench

MP_FIFO -- requirements
Module: mp_fifo

---
 rtl/mp_fifo_pkg.sv | 24 ++
 rtl/mp_fifo_popcount.sv | 19 +
 rtl/mp_fifo.sv | 152 +++++++++++++++
 tb/tb_mp_fifo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mp_fifo_pkg.sv
// Shared constants and pointer helpers for the multi-port FIFO.
package mp_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_NUM_WR     = 2;
    localparam int unsigned DEF_NUM_RD     = 2;
    localparam int unsigned DEF_INIT_COUNT = 0;
    localparam int unsigned DEF_INIT_START = 0;

    // Pointers carry one extra wrap bit above the memory index.
    function automatic int unsigned ptr_width(input int unsigned aw);
        return aw + 1;
    endfunction

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    function automatic int unsigned lane_cnt_width(input int unsigned lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/mp_fifo_popcount.sv
// Combinational ones counter used for write and read lane counts.
module popcount
    import mp_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    localparam int unsigned CW   = lane_cnt_width(WIDTH)
) (
    input  logic [WIDTH-1:0] bits_i,
    output logic [CW-1:0]    count_o
);

    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/mp_fifo.sv
// Multi-lane write / multi-lane read FIFO with read-pointer checkpointing
// and sticky overflow/underflow flags.
module mp_fifo
    import mp_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_WR     = DEF_NUM_WR,
    parameter int unsigned NUM_RD     = DEF_NUM_RD,
    parameter int unsigned INIT_COUNT = DEF_INIT_COUNT,
    parameter int unsigned INIT_START = DEF_INIT_START
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_WR-1:0]                   wr_en,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]   wr_data,
    input  logic [NUM_RD-1:0]                   rd_en,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]                   rd_valid,
    output logic [ADDR_WIDTH:0]                 count,
    output logic                                wr_ready,
    input  logic                                ckpt_save,
    input  logic                                ckpt_restore,
    output logic                                err_ovf,
    output logic                                err_udf
);

    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
    localparam int unsigned WCW   = lane_cnt_width(NUM_WR);
    localparam int unsigned RCW   = lane_cnt_width(NUM_RD);

    typedef logic [ptr_width(ADDR_WIDTH)-1:0] ptr_t;
    typedef logic [ADDR_WIDTH-1:0]            idx_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    ptr_t wr_ptr_q,   wr_ptr_d;
    ptr_t rd_ptr_q,   rd_ptr_d;
    ptr_t ckpt_ptr_q, ckpt_ptr_d;
    ptr_t rd_ptr_next;
    logic err_ovf_q,  err_ovf_d;
    logic err_udf_q,  err_udf_d;

    ptr_t              count_w;
    ptr_t              free_w;
    logic [WCW-1:0]    wr_cnt;
    logic [RCW-1:0]    rd_cnt;
    logic              wr_accept;
    logic [NUM_RD-1:0] pop_mask;
    logic              rd_bad;
    idx_t              wr_idx [NUM_WR];

    assign count_w  = wr_ptr_q - rd_ptr_q;
    assign free_w   = ptr_t'(DEPTH) - count_w;
    assign count    = count_w;
    assign wr_ready = (free_w >= ptr_t'(NUM_WR));
    assign err_ovf  = err_ovf_q;
    assign err_udf  = err_udf_q;

    popcount #(.WIDTH(NUM_WR)) u_wr_cnt (
        .bits_i  (wr_en),
        .count_o (wr_cnt)
    );

    popcount #(.WIDTH(NUM_RD)) u_rd_cnt (
        .bits_i  (pop_mask),
        .count_o (rd_cnt)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_data[i]  = mem_q[idx_t'(rd_ptr_q + ptr_t'(i))];
            rd_valid[i] = (count_w > ptr_t'(i));
        end
    end

    // Consume only the leading run of requested-and-valid lanes; any gap
    // in the request mask or a request past the valid entries is an error.
    always_comb begin : pop_select
        logic run;
        logic prev_en;
        pop_mask = '0;
        rd_bad   = 1'b0;
        run      = 1'b1;
        prev_en  = 1'b1;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (run && rd_en[i] && rd_valid[i]) begin
                pop_mask[i] = 1'b1;
            end else begin
                run = 1'b0;
            end
            if (rd_en[i] && !rd_valid[i]) rd_bad = 1'b1;
            if (rd_en[i] && !prev_en)     rd_bad = 1'b1;
            prev_en = rd_en[i];
        end
    end

    always_comb begin : wr_compact
        ptr_t ofs;
        ofs = '0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            wr_idx[j] = idx_t'(wr_ptr_q + ofs);
            if (wr_en[j]) ofs = ofs + ptr_t'(1);
        end
    end

    always_comb begin
        wr_accept   = (ptr_t'(wr_cnt) <= free_w);
        wr_ptr_d    = wr_accept ? (wr_ptr_q + ptr_t'(wr_cnt)) : wr_ptr_q;
        err_ovf_d   = err_ovf_q | ~wr_accept;
        rd_ptr_next = rd_ptr_q + ptr_t'(rd_cnt);
        rd_ptr_d    = rd_ptr_next;
        ckpt_ptr_d  = ckpt_ptr_q;
        err_udf_d   = err_udf_q | rd_bad;
        // Restore wins over save and discards this cycle's read request.
        if (ckpt_restore) begin
            rd_ptr_d  = ckpt_ptr_q;
            err_udf_d = err_udf_q;
        end else if (ckpt_save) begin
            ckpt_ptr_d = rd_ptr_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= ptr_t'(INIT_COUNT);
            rd_ptr_q   <= '0;
            ckpt_ptr_q <= '0;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ckpt_ptr_q <= ckpt_ptr_d;
            err_ovf_q  <= err_ovf_d;
            err_udf_q  <= err_udf_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i < INIT_COUNT) ? DATA_WIDTH'(INIT_START + i) : '0;
            end
        end else if (wr_accept) begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_en[j]) mem_q[wr_idx[j]] <= wr_data[j];
            end
        end
    end

endmodule

// File: tb/tb_mp_fifo.sv
// Directed bench for mp_fifo: preload drain, checkpoint rewind, underflow,
// async reset, pointer wrap and overflow.
module tb_mp_fifo;

    logic              clk;
    logic              reset;
    logic [1:0]        wr_en;
    logic [1:0][31:0]  wr_data;
    logic [1:0]        rd_en;
    logic [1:0][31:0]  rd_data;
    logic [1:0]        rd_valid;
    logic [4:0]        count;
    logic              wr_ready;
    logic              ckpt_save;
    logic              ckpt_restore;
    logic              err_ovf;
    logic              err_udf;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned exp_q[$];
    int unsigned next_val;

    mp_fifo #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (4),
        .NUM_WR     (2),
        .NUM_RD     (2),
        .INIT_COUNT (16),
        .INIT_START (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .wr_ready     (wr_ready),
        .ckpt_save    (ckpt_save),
        .ckpt_restore (ckpt_restore),
        .err_ovf      (err_ovf),
        .err_udf      (err_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_init_model();
        exp_q.delete();
        for (int unsigned i = 0; i < 16; i++) exp_q.push_back(32 + i);
    endtask

    initial begin
        reset = 1'b1; wr_en = '0; wr_data = '0; rd_en = '0;
        ckpt_save = 1'b0; ckpt_restore = 1'b0;
        #1;
        check_eq("rst_count",    count,      16);
        check_eq("rst_valid",    rd_valid,   2'b11);
        check_eq("rst_data0",    rd_data[0], 32);
        check_eq("rst_data1",    rd_data[1], 33);
        check_eq("rst_wr_ready", wr_ready,   0);
        check_eq("rst_ovf",      err_ovf,    0);
        check_eq("rst_udf",      err_udf,    0);
        step();
        reset = 1'b0;

        // Checkpoint at head, pop three pairs, rewind.
        ckpt_save = 1'b1;
        step();
        ckpt_save = 1'b0;
        rd_en = 2'b11;
        for (int unsigned k = 0; k < 3; k++) begin
            check_eq("ck_data0", rd_data[0], 32 + 2 * k);
            check_eq("ck_data1", rd_data[1], 33 + 2 * k);
            step();
        end
        check_eq("ck_count_popped", count, 10);
        ckpt_restore = 1'b1;
        step();
        ckpt_restore = 1'b0;
        rd_en = '0;
        check_eq("ck_count_restored", count, 16);
        check_eq("ck_data0_restored", rd_data[0], 32);
        check_eq("ck_udf", err_udf, 0);

        // Drain the preloaded contents in order.
        rd_en = 2'b11;
        for (int unsigned k = 0; k < 8; k++) begin
            check_eq("drain_count", count, 16 - 2 * k);
            check_eq("drain_data0", rd_data[0], 32 + 2 * k);
            check_eq("drain_data1", rd_data[1], 33 + 2 * k);
            step();
        end
        rd_en = '0;
        check_eq("drain_empty", count, 0);
        check_eq("drain_valid", rd_valid, 2'b00);
        check_eq("drain_wr_ready", wr_ready, 1);
        check_eq("drain_udf", err_udf, 0);

        // Lane-1-only write compacts into slot 0; no same-cycle bypass.
        wr_en = 2'b10;
        wr_data[0] = 32'hDEAD;
        wr_data[1] = 32'hA5;
        check_eq("wr_nobypass_valid", rd_valid, 2'b00);
        step();
        wr_en = '0;
        check_eq("wr_data0", rd_data[0], 32'hA5);
        check_eq("wr_valid", rd_valid, 2'b01);
        check_eq("wr_count", count, 1);
        rd_en = 2'b11;
        step();
        rd_en = '0;
        check_eq("udf_flag", err_udf, 1);
        check_eq("udf_count", count, 0);

        // Async reset in the middle of active traffic.
        wr_en = 2'b11; wr_data[0] = 1; wr_data[1] = 2; rd_en = 2'b11;
        step();
        check_eq("pre_rst_count", count, 2);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_count", count, 16);
        check_eq("arst_udf",   err_udf, 0);
        check_eq("arst_data0", rd_data[0], 32);
        check_eq("arst_valid", rd_valid, 2'b11);
        step();
        check_eq("arst_hold_count", count, 16);
        wr_en = '0; rd_en = '0;
        reset = 1'b0;
        load_init_model();

        // Bring occupancy to 4, then stream with wrapping pointers.
        rd_en = 2'b11;
        for (int unsigned k = 0; k < 6; k++) begin
            step();
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
        end
        rd_en = '0;
        check_eq("wrap_pre_count", count, 4);
        check_eq("wrap_pre_ready", wr_ready, 1);
        next_val = 100;
        wr_en = 2'b11; rd_en = 2'b11;
        for (int unsigned k = 0; k < 40; k++) begin
            wr_data[0] = next_val;
            wr_data[1] = next_val + 1;
            check_eq("wrap_count", count, 4);
            check_eq("wrap_data0", rd_data[0], exp_q[0]);
            check_eq("wrap_data1", rd_data[1], exp_q[1]);
            step();
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
            exp_q.push_back(next_val);
            exp_q.push_back(next_val + 1);
            next_val += 2;
        end
        wr_en = '0; rd_en = '0;
        check_eq("wrap_post_count", count, 4);
        check_eq("wrap_post_data0", rd_data[0], exp_q[0]);
        check_eq("wrap_post_ovf", err_ovf, 0);
        check_eq("wrap_post_udf", err_udf, 0);

        // Fill to 15, attempt a two-lane write, then a single-lane write.
        wr_en = 2'b01;
        for (int unsigned k = 0; k < 11; k++) begin
            wr_data[0] = next_val;
            step();
            exp_q.push_back(next_val);
            next_val++;
        end
        check_eq("fill_count", count, 15);
        check_eq("fill_ready", wr_ready, 0);
        wr_en = 2'b11; wr_data[0] = 32'h111; wr_data[1] = 32'h222;
        step();
        check_eq("ovf_count", count, 15);
        check_eq("ovf_flag", err_ovf, 1);
        wr_en = 2'b01; wr_data[0] = next_val;
        step();
        exp_q.push_back(next_val);
        wr_en = '0;
        check_eq("full_count", count, 16);
        check_eq("full_ready", wr_ready, 0);
        check_eq("full_data0", rd_data[0], exp_q[0]);
        check_eq("full_data1", rd_data[1], exp_q[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
